ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-cycle arbiter that shares one single-port synchronous program RAM between the Kronos instruction fetch bus, the Kronos data bus and the ioctl program-upload port. It sits between the core and the RAM, downstream of address decode, so every data request it receives targets RAM. It sequences each core access as issue-then-acknowledge. It applies round-robin fairness between fetch and data, and gives upload writes absolute priority.

## Interface

Parameters:
- ADDR_WIDTH, 15, RAM word-address width (2^ADDR_WIDTH 32-bit words; 15 = 128 KiB).

Ports:
- clk  in  1  system clock.
- rstz  in  1  asynchronous, active-low reset.
- inst_addr  in  32  fetch byte address.
- inst_req  in  1  fetch request, held until acked.
- inst_ack  out  1  one-cycle fetch completion.
- inst_q  out  32  fetch data, valid with inst_ack.
- data_addr  in  32  load/store byte address.
- data_wdata  in  32  store data.
- data_mask  in  4  store byte enables.
- data_wren  in  1  1 = store, 0 = load.
- data_req  in  1  data request, held until acked.
- data_ack  out  1  one-cycle data completion.
- data_q  out  32  load data, valid with data_ack.
- ioctl_download  in  1  upload in progress.
- ioctl_addr  in  17  upload byte address.
- ioctl_dout  in  32  upload word.
- ioctl_wr  in  1  upload write strobe (single-cycle pulse).
- mem_addr  out  ADDR_WIDTH  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_be  out  4  RAM byte enables.
- mem_we  out  1  RAM write enable.
- mem_q  in  32  RAM read data, registered (valid the cycle after address).

## Operation

- The FSM has two states: IDLE (issue) and ACK (complete). The state register holds the granted source (INST or DATA) and a 1-bit round-robin pointer `last`.
- Core grant in IDLE requires ioctl_download = 0 and rstz = 1.
- Only one of inst_req / data_req high: that source is granted.
- Both high: grant the source not equal to `last`.
- `last` updates on every core grant.
- No request: stay in IDLE, with mem_we = 0 and mem_be = 0.
- Granted cycle (IDLE):
  - mem_addr = addr[ADDR_WIDTH+1:2].
  - Store: mem_we = 1, mem_be = data_mask, mem_wdata = data_wdata.
  - Load or fetch: mem_we = 0.
  - Next state is ACK.
- ACK cycle:
  - Assert the granted source's ack for exactly one cycle.
  - Load/fetch: q = mem_q.
  - Next state is IDLE unconditionally. A request still high in ACK is not re-issued.
- Out-of-range address (addr[31:ADDR_WIDTH+2] ≠ 0):
  - Still granted and acked on the normal schedule.
  - mem_we forced 0, and the returned q = 0.
  - The flag is registered at issue.
- Upload:
  - Whenever ioctl_download = 1 and ioctl_wr = 1, in any state, drive mem_addr = ioctl_addr[ADDR_WIDTH+1:2], mem_wdata = ioctl_dout, mem_be = 4'hF, mem_we = 1.
  - ioctl_wr with ioctl_download = 0 is ignored.
  - An upload write in ACK does not corrupt that cycle's q, because mem_q reflects the prior-cycle read.
  - Download rising while in ACK: the in-flight ack still completes. Pending core requests then stall, with no ack, until download falls.
- inst_q and data_q are 0 whenever their ack is 0.

## Timing

- Reset values: state IDLE; last = DATA, so INST wins the first tie; inst_ack = data_ack = 0; inst_q = data_q = 0.
- While rstz = 0, mem_we = 0 and mem_be = 0, with grants gated directly by rstz.
- Reset asserted mid-access (including in ACK): acks drop immediately, and any pending access is abandoned with no ack.
- Latency: request seen in IDLE at cycle N, ack at N+1, next issue no earlier than N+2. Peak throughput is one access per 2 cycles.
- Simultaneous requests: the loser waits exactly 2 cycles (acked at N+3) if no upload intervenes.
- Memory-side outputs are combinational from state and inputs. Ack and q are combinational from the registered ACK state, the granted source and mem_q.
- Loads ignore data_mask and always return the full word.

## Test plan

- Fetch alone: RAM word 4 preloaded with 0x00000013; inst_req = 1, inst_addr = 0x10 → inst_ack high exactly one cycle later for one cycle, inst_q = 0x00000013, data_ack stays 0.
- Tie fairness: after reset, inst_req and data_req both held → inst_ack at N+1, data_ack at N+3. Repeat the tie → data_ack at N+1, inst_ack at N+3.
- Byte store: word 8 = 0x11223344; data store of 0xAABBCCDD, mask 4'b0100, addr 0x20 → data_ack at N+1. A load from 0x20 then returns 0x11BB3344.
- Upload priority: ioctl_download = 1 with inst_req held; three ioctl_wr pulses to byte addresses 0, 4, 8 → each gives mem_we = 1 and mem_be = 4'hF at word 0/1/2, with no inst_ack. Download falls → inst_ack 1 cycle after the next IDLE.
- Out of range (ADDR_WIDTH = 15): data load at 0x00020000 → data_ack at N+1 with data_q = 0. A store to the same address → acked, mem_we never 1.
- Reset in ACK: rstz low during the ACK cycle of a fetch → inst_ack = 0 immediately. After release, a tie grants INST first.

Source files
------------

// File: rtl/ram_arbiter.sv
// Purpose : shares one single-port synchronous program RAM between the core
//           fetch bus, the core data bus and the ioctl program-upload port.
// Latency : request seen in IDLE at cycle N is acked at N+1, next issue at N+2.
// Backpressure: requests are held until acked; upload writes always win and
//           stall core grants while ioctl_download is high.
//
// Ports:
//   clk, rstz                      clock, asynchronous active-low reset
//   inst_addr/req -> inst_ack/q    instruction fetch bus (read only)
//   data_addr/wdata/mask/wren/req  load/store bus
//     -> data_ack/q
//   ioctl_download/addr/dout/wr    program upload port (word writes)
//   mem_addr/wdata/be/we, mem_q    RAM side; mem_q is registered (1-cycle read)
module ram_arbiter #(
   parameter int ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  rstz,
   // instruction fetch bus
   input  logic [31:0]           inst_addr,
   input  logic                  inst_req,
   output logic                  inst_ack,
   output logic [31:0]           inst_q,
   // data bus
   input  logic [31:0]           data_addr,
   input  logic [31:0]           data_wdata,
   input  logic [3:0]            data_mask,
   input  logic                  data_wren,
   input  logic                  data_req,
   output logic                  data_ack,
   output logic [31:0]           data_q,
   // program upload
   input  logic                  ioctl_download,
   input  logic [16:0]           ioctl_addr,
   input  logic [31:0]           ioctl_dout,
   input  logic                  ioctl_wr,
   // RAM side
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_be,
   output logic                  mem_we,
   input  logic [31:0]           mem_q
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_t;

   typedef enum logic {
      SRC_INST = 1'b0,
      SRC_DATA = 1'b1
   } src_t;

   state_t state_q, state_d;
   src_t   src_q,   src_d;    // source granted in the last issue cycle
   src_t   last_q,  last_d;   // round-robin pointer: last core source granted
   logic   oor_q,   oor_d;    // granted access was outside the RAM

   logic        grant_en;
   logic        req_any;
   logic        pick_data;
   logic        grant;
   logic        upload;
   logic [31:0] sel_addr;
   logic        sel_oor;
   logic [31:0] ioctl_addr_ext;
   logic        ack_active;

   // Zero-extended so the word slice below stays legal for any ADDR_WIDTH.
   assign ioctl_addr_ext = {15'b0, ioctl_addr};

   // Core grants only happen from IDLE, outside reset and outside an upload.
   // rstz is folded in combinationally so nothing is issued while reset is low.
   assign grant_en = rstz & ~ioctl_download & (state_q == ST_IDLE);
   assign req_any  = inst_req | data_req;

   // On a tie the source that did not win last time is chosen.
   assign pick_data = data_req & (~inst_req | (last_q == SRC_INST));
   assign grant     = grant_en & req_any;

   assign sel_addr = pick_data ? data_addr : inst_addr;
   assign sel_oor  = |sel_addr[31:ADDR_WIDTH+2];

   // Upload writes are honoured in any state, but never during reset.
   assign upload = rstz & ioctl_download & ioctl_wr;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state_q <= ST_IDLE;
         src_q   <= SRC_INST;
         last_q  <= SRC_DATA;   // INST wins the first tie after reset
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         last_q  <= last_d;
         oor_q   <= oor_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      last_d  = last_q;
      oor_d   = oor_q;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d = ST_ACK;
               src_d   = src_t'(pick_data);
               last_d  = src_t'(pick_data);
               oor_d   = sel_oor;
            end
         end
         ST_ACK: begin
            // A request still high here was already served; it is not
            // re-issued, the master drops it after seeing the ack.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // RAM side (combinational from state and inputs)
   // ------------------------------------------------------------------
   always_comb begin
      mem_addr  = sel_addr[ADDR_WIDTH+1:2];
      mem_wdata = data_wdata;
      mem_be    = 4'h0;
      mem_we    = 1'b0;
      // Stores outside the RAM are acked but never written.
      if (grant && pick_data && data_wren && !sel_oor) begin
         mem_we = 1'b1;
         mem_be = data_mask;
      end
      // Upload overrides everything; during ACK this is safe because mem_q
      // already holds the read launched in the preceding issue cycle.
      if (upload) begin
         mem_addr  = ioctl_addr_ext[ADDR_WIDTH+1:2];
         mem_wdata = ioctl_dout;
         mem_be    = 4'hF;
         mem_we    = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Completion side (combinational from registered ACK state and mem_q)
   // ------------------------------------------------------------------
   assign ack_active = rstz & (state_q == ST_ACK);
   assign inst_ack   = ack_active & (src_q == SRC_INST);
   assign data_ack   = ack_active & (src_q == SRC_DATA);
   assign inst_q     = (inst_ack && !oor_q) ? mem_q : 32'h0;
   assign data_q     = (data_ack && !oor_q) ? mem_q : 32'h0;

   // Byte-offset bits and the constant upper upload bits carry no information.
   logic unused_ok;
   assign unused_ok = &{1'b0, inst_addr[1:0], data_addr[1:0],
                        ioctl_addr_ext[31:ADDR_WIDTH+2], ioctl_addr_ext[1:0]};

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural byte-enabled synchronous
// RAM attached to the memory port. Inputs change 2 time units after the rising
// edge; outputs are sampled 1 unit later, well away from either clock edge.
module tb_ram_arbiter;

   logic        clk;
   logic        rstz;
   logic [31:0] inst_addr;
   logic        inst_req;
   logic        inst_ack;
   logic [31:0] inst_q;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_mask;
   logic        data_wren;
   logic        data_req;
   logic        data_ack;
   logic [31:0] data_q;
   logic        ioctl_download;
   logic [16:0] ioctl_addr;
   logic [31:0] ioctl_dout;
   logic        ioctl_wr;
   logic [14:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_we;
   logic [31:0] mem_q;

   int total;
   int passed;

   ram_arbiter #(.ADDR_WIDTH(15)) dut (
      .clk            (clk),
      .rstz           (rstz),
      .inst_addr      (inst_addr),
      .inst_req       (inst_req),
      .inst_ack       (inst_ack),
      .inst_q         (inst_q),
      .data_addr      (data_addr),
      .data_wdata     (data_wdata),
      .data_mask      (data_mask),
      .data_wren      (data_wren),
      .data_req       (data_req),
      .data_ack       (data_ack),
      .data_q         (data_q),
      .ioctl_download (ioctl_download),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wr       (ioctl_wr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_be         (mem_be),
      .mem_we         (mem_we),
      .mem_q          (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous RAM, read-before-write, registered output.
   logic [31:0] ram [0:32767];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (mem_we && mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_q <= ram[mem_addr];
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic [16:0] up_addr [5];
   logic [31:0] up_data [5];

   initial begin
      total = 0;
      passed = 0;
      up_addr[0] = 17'h00000; up_data[0] = 32'hA0A0A0A0;
      up_addr[1] = 17'h00004; up_data[1] = 32'hA1A1A1A1;
      up_addr[2] = 17'h00008; up_data[2] = 32'hA2A2A2A2;
      up_addr[3] = 17'h00010; up_data[3] = 32'h00000013;
      up_addr[4] = 17'h00020; up_data[4] = 32'h11223344;

      rstz = 1'b0;
      inst_addr = '0; inst_req = 1'b0;
      data_addr = '0; data_wdata = '0; data_mask = '0; data_wren = 1'b0; data_req = 1'b0;
      ioctl_download = 1'b0; ioctl_addr = '0; ioctl_dout = '0; ioctl_wr = 1'b0;

      // ---- reset state ----
      #3;
      chk("rst_inst_ack", 32'(inst_ack), 32'h0);
      chk("rst_data_ack", 32'(data_ack), 32'h0);
      chk("rst_inst_q",   inst_q, 32'h0);
      chk("rst_data_q",   data_q, 32'h0);
      data_req = 1'b1; data_wren = 1'b1; data_mask = 4'hF;
      #1;
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_be", 32'(mem_be), 32'h0);
      tick; tick;
      data_req = 1'b0; data_wren = 1'b0; data_mask = 4'h0;
      rstz = 1'b1;
      tick;

      // ---- upload priority with a fetch held pending ----
      ioctl_download = 1'b1;
      inst_req = 1'b1; inst_addr = 32'h10;
      #1;
      chk("dl_no_grant_we", 32'(mem_we), 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick;
         ioctl_wr = 1'b1; ioctl_addr = up_addr[i]; ioctl_dout = up_data[i];
         #1;
         chk("up_we",    32'(mem_we), 32'h1);
         chk("up_be",    32'(mem_be), 32'hF);
         chk("up_addr",  32'(mem_addr), 32'(up_addr[i] >> 2));
         chk("up_wdata", mem_wdata, up_data[i]);
         chk("up_no_ack", 32'(inst_ack), 32'h0);
         tick;
         ioctl_wr = 1'b0;
         #1;
         chk("up_gap_no_ack", 32'(inst_ack), 32'h0);
         chk("up_gap_we",     32'(mem_we), 32'h0);
      end

      // ---- download falls: held fetch issues, then acks one cycle later ----
      tick;
      ioctl_download = 1'b0;
      #1;
      chk("fetch_issue_addr", 32'(mem_addr), 32'h4);
      chk("fetch_issue_we",   32'(mem_we), 32'h0);
      chk("fetch_issue_ack",  32'(inst_ack), 32'h0);
      tick; #1;
      chk("fetch_ack",      32'(inst_ack), 32'h1);
      chk("fetch_q",        inst_q, 32'h00000013);
      chk("fetch_data_ack", 32'(data_ack), 32'h0);
      inst_req = 1'b0;
      tick; #1;
      chk("fetch_ack_1cyc", 32'(inst_ack), 32'h0);
      chk("fetch_q_zero",   inst_q, 32'h0);

      // ---- tie after an INST grant: DATA first, INST two cycles later ----
      inst_req = 1'b1; inst_addr = 32'h10;
      data_req = 1'b1; data_addr = 32'h20; data_wren = 1'b0;
      #1;
      chk("tie1_issue_addr", 32'(mem_addr), 32'h8);
      tick; #1;
      chk("tie1_data_ack", 32'(data_ack), 32'h1);
      chk("tie1_data_q",   data_q, 32'h11223344);
      chk("tie1_inst_wait", 32'(inst_ack), 32'h0);
      data_req = 1'b0;
      tick; #1;
      chk("tie1_n2_inst", 32'(inst_ack), 32'h0);
      chk("tie1_n2_data", 32'(data_ack), 32'h0);
      chk("tie1_n2_addr", 32'(mem_addr), 32'h4);
      tick; #1;
      chk("tie1_inst_ack", 32'(inst_ack), 32'h1);
      chk("tie1_inst_q",   inst_q, 32'h00000013);
      inst_req = 1'b0;
      tick;

      // ---- byte store then load back ----
      data_req = 1'b1; data_addr = 32'h20; data_wren = 1'b1;
      data_wdata = 32'hAABBCCDD; data_mask = 4'b0100;
      #1;
      chk("st_we",    32'(mem_we), 32'h1);
      chk("st_be",    32'(mem_be), 32'h4);
      chk("st_addr",  32'(mem_addr), 32'h8);
      chk("st_wdata", mem_wdata, 32'hAABBCCDD);
      tick; #1;
      chk("st_ack", 32'(data_ack), 32'h1);
      chk("st_ack_we", 32'(mem_we), 32'h0);
      data_req = 1'b0;
      tick;
      data_req = 1'b1; data_wren = 1'b0; data_mask = 4'h1;
      #1;
      chk("ld_we", 32'(mem_we), 32'h0);
      tick; #1;
      chk("ld_ack", 32'(data_ack), 32'h1);
      chk("ld_q",   data_q, 32'h11BB3344);
      data_req = 1'b0;
      tick;

      // ---- out-of-range load and store ----
      data_req = 1'b1; data_addr = 32'h00020000; data_wren = 1'b0; data_mask = 4'hF;
      #1;
      chk("oor_ld_we", 32'(mem_we), 32'h0);
      tick; #1;
      chk("oor_ld_ack", 32'(data_ack), 32'h1);
      chk("oor_ld_q",   data_q, 32'h0);
      data_req = 1'b0;
      tick;
      data_req = 1'b1; data_wren = 1'b1; data_wdata = 32'hDEADBEEF;
      #1;
      chk("oor_st_we", 32'(mem_we), 32'h0);
      tick; #1;
      chk("oor_st_ack",    32'(data_ack), 32'h1);
      chk("oor_st_ack_we", 32'(mem_we), 32'h0);
      data_req = 1'b0; data_wren = 1'b0;
      tick;

      // ---- ioctl_wr without download is ignored ----
      ioctl_wr = 1'b1; ioctl_addr = 17'h0; ioctl_dout = 32'h12345678;
      #1;
      chk("wr_no_dl_we", 32'(mem_we), 32'h0);
      tick;
      ioctl_wr = 1'b0;
      data_req = 1'b1; data_addr = 32'h0;
      tick; #1;
      chk("word0_ack", 32'(data_ack), 32'h1);
      chk("word0_q",   data_q, 32'hA0A0A0A0);
      data_req = 1'b0;
      tick;

      // ---- upload during ACK; download then stalls a pending load ----
      inst_req = 1'b1; inst_addr = 32'h10;
      tick;
      ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 17'h10; ioctl_dout = 32'h00000055;
      data_req = 1'b1; data_addr = 32'h10;
      #1;
      chk("ackup_inst_ack", 32'(inst_ack), 32'h1);
      chk("ackup_inst_q",   inst_q, 32'h00000013);
      chk("ackup_we",       32'(mem_we), 32'h1);
      inst_req = 1'b0;
      tick;
      ioctl_wr = 1'b0;
      #1;
      chk("stall1_data_ack", 32'(data_ack), 32'h0);
      chk("stall1_we",       32'(mem_we), 32'h0);
      tick; #1;
      chk("stall2_data_ack", 32'(data_ack), 32'h0);
      ioctl_download = 1'b0;
      tick; #1;
      chk("unstall_data_ack", 32'(data_ack), 32'h1);
      chk("unstall_data_q",   data_q, 32'h00000055);
      data_req = 1'b0;
      tick;

      // ---- reset during ACK, then INST wins the first tie ----
      inst_req = 1'b1; inst_addr = 32'h10;
      tick; #1;
      chk("rack_pre_ack", 32'(inst_ack), 32'h1);
      rstz = 1'b0;
      #1;
      chk("rack_ack_drop", 32'(inst_ack), 32'h0);
      chk("rack_q_drop",   inst_q, 32'h0);
      tick;
      inst_req = 1'b0;
      rstz = 1'b1;
      tick;
      inst_req = 1'b1; inst_addr = 32'h10;
      data_req = 1'b1; data_addr = 32'h20; data_wren = 1'b0;
      #1;
      chk("tie2_issue_addr", 32'(mem_addr), 32'h4);
      tick; #1;
      chk("tie2_inst_ack", 32'(inst_ack), 32'h1);
      chk("tie2_data_wait", 32'(data_ack), 32'h0);
      inst_req = 1'b0;
      tick; #1;
      chk("tie2_n2_data", 32'(data_ack), 32'h0);
      tick; #1;
      chk("tie2_data_ack", 32'(data_ack), 32'h1);
      chk("tie2_data_q",   data_q, 32'h11BB3344);
      data_req = 1'b0;
      tick;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
